// File: rtl/boot_loader.sv
// Framed byte-stream loader for the 16-word CPU RAM.
// Optional trailing XOR checksum byte: define BOOT_CHECKSUM_EN.
module boot_loader #(
  parameter int DEPTH     = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        RAM_load,
  output logic [15:0] RAM_data,
  output logic [15:0] RAM_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] LIMIT = 16'(DEPTH - BASE_ADDR);
  localparam logic [15:0] BASE  = 16'(BASE_ADDR);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
`ifdef BOOT_CHECKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  hi_q;
  logic [15:0] count_q;
  logic [15:0] words_q;
  logic [15:0] data_q;
  logic        xfer;
  logic        can_start;
  logic [15:0] hdr;
  logic [15:0] wl_inc;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  xsum_q;
`endif

  assign xfer      = byte_valid && byte_ready;
  assign hdr       = {hi_q, byte_in};
  assign wl_inc    = words_q + 16'd1;
  assign can_start = (state == S_IDLE) || (state == S_DONE) ||
                     (state == S_ERROR);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    RAM_load   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_HDR_HI;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_nx = S_HDR_HI;
      end
      S_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) state_nx = S_HDR_HI;
      end
      S_HDR_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_nx = S_HDR_LO;
      end
      S_HDR_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (hdr == 16'd0)     state_nx = S_DONE;
          else if (hdr > LIMIT) state_nx = S_ERROR;
          else                  state_nx = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_nx = S_DATA_LO;
      end
      S_DATA_LO: begin
        byte_ready = 1'b1;
        if (xfer) state_nx = S_WRITE;
      end
      S_WRITE: begin
        RAM_load = 1'b1;
        if (wl_inc == count_q) begin
`ifdef BOOT_CHECKSUM_EN
          state_nx = S_CKSUM;
`else
          state_nx = S_DONE;
`endif
        end else begin
          state_nx = S_DATA_HI;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CKSUM: begin
        byte_ready = 1'b1;
        if (xfer) state_nx = (byte_in == xsum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Header capture, word assembly and write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= 8'd0;
      count_q <= 16'd0;
      words_q <= 16'd0;
      data_q  <= 16'd0;
    end else begin
      if (can_start && start) words_q <= 16'd0;
      if (xfer && state == S_HDR_HI) hi_q <= byte_in;
      if (xfer && state == S_HDR_LO) count_q <= hdr;
      if (xfer && state == S_DATA_HI) data_q[15:8] <= byte_in;
      if (xfer && state == S_DATA_LO) data_q[7:0] <= byte_in;
      if (state == S_WRITE) words_q <= wl_inc;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running XOR over data bytes only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsum_q <= 8'd0;
    end else begin
      if (can_start && start) xsum_q <= 8'd0;
      else if (xfer && (state == S_DATA_HI || state == S_DATA_LO))
        xsum_q <= xsum_q ^ byte_in;
    end
  end
`endif

  assign RAM_data     = data_q;
  assign RAM_addr     = BASE + words_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader.
// Expected RAM writes and final status come from the frame contents.
module tb_boot_loader;

`ifdef BOOT_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        RAM_load;
  logic [15:0] RAM_data;
  logic [15:0] RAM_addr;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  bit prev_load = 1'b0;
  logic [15:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [15:0] words[$];
  logic [15:0] mem [0:15];

  boot_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .RAM_load(RAM_load),
    .RAM_data(RAM_data), .RAM_addr(RAM_addr),
    .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every RAM write must match the next expected (addr, data).
  always @(negedge clk) begin
    if (rst) begin
      prev_load = 1'b0;
    end else begin
      if (RAM_load) begin
        pulses++;
        chk("load_not_consecutive", {31'd0, prev_load}, 32'd0);
        if (exp_addr.size() == 0) begin
          chk("load_unexpected", 32'd1, 32'd0);
        end else begin
          chk("ram_addr", {16'd0, RAM_addr}, {16'd0, exp_addr[0]});
          chk("ram_data", {16'd0, RAM_data}, {16'd0, exp_data[0]});
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
        if (RAM_addr < 16) mem[RAM_addr[3:0]] = RAM_data;
      end
      prev_load = RAM_load;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    k = 0;
    while (!byte_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  // Frame with header n and payload in words[]; model decides outcome.
  task automatic run_load(input logic [15:0] n, input int maxgap,
                          input bit midstart, input bit badsum);
    bit ok;
    bit exp_err;
    logic [7:0] x;
    int p0;
    ok = (n <= 16);
    x = 8'd0;
    p0 = pulses;
    if (ok)
      for (int i = 0; i < int'(n); i++) begin
        exp_addr.push_back(16'(i));
        exp_data.push_back(words[i]);
        x = x ^ words[i][15:8] ^ words[i][7:0];
      end
    pulse_start();
    send_byte(n[15:8], $urandom_range(maxgap, 0));
    send_byte(n[7:0], $urandom_range(maxgap, 0));
    if (ok && n != 0) begin
      if (midstart) pulse_start();
      for (int i = 0; i < int'(n); i++) begin
        send_byte(words[i][15:8], $urandom_range(maxgap, 0));
        send_byte(words[i][7:0], $urandom_range(maxgap, 0));
      end
      if (CK) send_byte(badsum ? ~x : x, $urandom_range(maxgap, 0));
    end
    wait_idle();
    exp_err = !ok || (CK && badsum && n != 0);
    chk("error", {31'd0, error}, {31'd0, exp_err});
    chk("done", {31'd0, done}, {31'd0, !exp_err});
    chk("words_loaded", {16'd0, words_loaded},
        ok ? {16'd0, n} : 32'd0);
    chk("byte_ready_idle", {31'd0, byte_ready}, 32'd0);
    chk("pulse_count", pulses - p0, ok ? int'(n) : 0);
    chk("writes_pending", exp_addr.size(), 32'd0);
  endtask

  initial begin
    int n;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_load", {31'd0, RAM_load}, 32'd0);
    chk("rst_addr", {16'd0, RAM_addr}, 32'd0);
    chk("rst_data", {16'd0, RAM_data}, 32'd0);
    chk("rst_wl", {16'd0, words_loaded}, 32'd0);
    rst = 1'b0;

    // Basic two-word frame, back-to-back bytes.
    words = '{16'h1234, 16'hABCD};
    run_load(16'd2, 0, 1'b0, 1'b0);
    chk("lit_mem0", {16'd0, mem[0]}, 32'h1234);
    chk("lit_mem1", {16'd0, mem[1]}, 32'hABCD);

    // Literal checksum cases (0x12 ^ 0x34 = 0x26).
    if (CK) begin
      words = '{16'h1234};
      run_load(16'd1, 0, 1'b0, 1'b0);
      chk("lit_ck_done", {31'd0, done}, 32'd1);
      run_load(16'd1, 0, 1'b0, 1'b1);
      chk("lit_ck_err", {31'd0, error}, 32'd1);
      chk("lit_ck_mem0", {16'd0, mem[0]}, 32'h1234);
    end

    // Range errors and the N == DEPTH boundary.
    run_load(16'd17, 0, 1'b0, 1'b0);
    chk("lit_n17_err", {31'd0, error}, 32'd1);
    run_load(16'h0100, 2, 1'b0, 1'b0);
    run_load(16'hFFFF, 1, 1'b0, 1'b0);
    words = {};
    for (int i = 0; i < 16; i++) words.push_back(16'($urandom));
    run_load(16'd16, 0, 1'b0, 1'b0);
    chk("lit_mem15", {16'd0, mem[15]}, {16'd0, words[15]});

    // Empty frame, restart from DONE, stray valid bytes ignored.
    run_load(16'd0, 0, 1'b0, 1'b0);
    pulse_start();
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_idle();
    chk("n0_done", {31'd0, done}, 32'd1);
    byte_in = 8'hFF;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    chk("stray_done", {31'd0, done}, 32'd1);
    chk("stray_busy", {31'd0, busy}, 32'd0);

    // Randomized frames with gaps and a start pulse mid-load.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(16, 1);
      words = {};
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      run_load(16'(n), 5, t[0], t[1] & t[2]);
    end
    words = '{16'h0102, 16'h0304, 16'h0506};
    run_load(16'd3, 5, 1'b1, 1'b0);
    chk("lit_gap_mem2", {16'd0, mem[2]}, 32'h0506);

    // Reset while in DATA_LO of word 2.
    exp_addr.push_back(16'd0);
    exp_data.push_back(16'h1122);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_load", {31'd0, RAM_load}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("mid_rst_wl", {16'd0, words_loaded}, 32'd0);
    chk("mid_rst_data", {16'd0, RAM_data}, 32'd0);
    chk("mid_rst_addr", {16'd0, RAM_addr}, 32'd0);
    chk("mid_rst_pending", exp_addr.size(), 32'd0);
    exp_addr = {};
    exp_data = {};
    @(negedge clk);
    rst = 1'b0;
    words = '{16'hBEEF};
    run_load(16'd1, 0, 1'b0, 1'b0);
    chk("lit_after_rst", {16'd0, mem[0]}, 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
